// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - KMBox bridge protocol constants and decoder state encoding.
package bridge_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] CMD_PING  = 8'h01;
  localparam logic [7:0] CMD_PONG  = 8'h81;
  localparam logic [7:0] CMD_MOUSE = 8'h10;
  localparam logic [7:0] CMD_KBD   = 8'h20;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_EMIT    = 3'd5
  } dec_state_e;

endpackage

// File: rtl/bridge_frame_buf.sv
// rtl/bridge_frame_buf.sv - single-port payload buffer, synchronous write, registered read.
module bridge_frame_buf #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Addresses past the frame end occur while prefetching after the last payload beat; ignore them.
  always_ff @(posedge clk) begin
    if (we_i && (addr_i < 8'(DEPTH))) begin
      mem_q[addr_i[AW-1:0]] <= wdata_i;
    end
    if (addr_i < 8'(DEPTH)) begin
      rdata_q <= mem_q[addr_i[AW-1:0]];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bridge_rsp_decoder.sv
// rtl/bridge_rsp_decoder.sv - sync hunt, frame parse/check and valid/ready replay of bridge responses.
// Error counters are built only when BRIDGE_DEC_STATS_EN is defined.
module bridge_rsp_decoder
  import bridge_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pong_seen,
  output logic       busy
`ifdef BRIDGE_DEC_STATS_EN
  ,
  output logic [7:0] err_chk,
  output logic [7:0] err_len,
  output logic [7:0] err_tmo,
  output logic [7:0] err_ovr
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  dec_state_e    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, len_q, len_d, sum_q, sum_d, idx_q, idx_d;
  logic [8:0]    beat_q, beat_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          buf_we, hs;
  logic [7:0]    buf_addr, buf_rdata;
  logic          ev_chk, ev_len, ev_tmo, ev_ovr;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    tmr_d       = tmr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    buf_we      = 1'b0;
    ev_chk      = 1'b0;
    ev_len      = 1'b0;
    ev_tmo      = 1'b0;
    ev_ovr      = 1'b0;
    hs          = out_valid_q && out_ready;

    case (state_q)
      ST_HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_CMD;
          tmr_d   = '0;
        end
      end
      ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK: begin
        tmr_d = tmr_q + 1'b1;
        if (rx_frame_err) begin
          state_d = ST_HUNT;
          ev_tmo  = 1'b1;
        end else if (rx_valid) begin
          tmr_d = '0;
          sum_d = sum_q + rx_data;
          case (state_q)
            ST_CMD: begin
              cmd_d   = rx_data;
              sum_d   = rx_data;
              state_d = ST_LEN;
            end
            ST_LEN: begin
              len_d = rx_data;
              idx_d = '0;
              if (rx_data > 8'(MAX_LEN)) begin
                state_d = ST_HUNT;
                ev_len  = 1'b1;
              end else begin
                state_d = (rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              buf_we = 1'b1;
              idx_d  = idx_q + 1'b1;
              if (idx_d == len_q) state_d = ST_CHK;
            end
            default: begin
              if (rx_data == sum_q) begin
                state_d     = ST_EMIT;
                out_valid_d = 1'b1;
                out_data_d  = cmd_q;
                out_last_d  = 1'b0;
                beat_d      = '0;
                idx_d       = '0;
              end else begin
                state_d = ST_HUNT;
                ev_chk  = 1'b1;
              end
            end
          endcase
        end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_HUNT;
          ev_tmo  = 1'b1;
        end
      end
      ST_EMIT: begin
        ev_ovr = rx_valid;
        if (hs) begin
          if (out_last_q) begin
            state_d     = ST_HUNT;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
            if (beat_q == 9'd0) begin
              out_data_d = len_q;
              out_last_d = (len_q == 8'd0);
            end else begin
              // Payload beat: buffer already holds entry idx_q; advance so the next one is prefetched.
              out_data_d = buf_rdata;
              idx_d      = idx_q + 1'b1;
              out_last_d = (beat_q == {1'b0, len_q});
            end
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    buf_addr = buf_we ? idx_q : idx_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      cmd_q       <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      tmr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      tmr_q       <= tmr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  bridge_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .addr_i  (buf_addr),
    .wdata_i (rx_data),
    .rdata_o (buf_rdata)
  );

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_HUNT);
  assign pong_seen = (state_q == ST_EMIT) && hs && out_last_q && (cmd_q == CMD_PONG);

`ifdef BRIDGE_DEC_STATS_EN
  logic [7:0] err_chk_q, err_len_q, err_tmo_q, err_ovr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_chk_q <= '0;
      err_len_q <= '0;
      err_tmo_q <= '0;
      err_ovr_q <= '0;
    end else begin
      if (ev_chk && (err_chk_q != 8'hFF)) err_chk_q <= err_chk_q + 1'b1;
      if (ev_len && (err_len_q != 8'hFF)) err_len_q <= err_len_q + 1'b1;
      if (ev_tmo && (err_tmo_q != 8'hFF)) err_tmo_q <= err_tmo_q + 1'b1;
      if (ev_ovr && (err_ovr_q != 8'hFF)) err_ovr_q <= err_ovr_q + 1'b1;
    end
  end

  assign err_chk = err_chk_q;
  assign err_len = err_len_q;
  assign err_tmo = err_tmo_q;
  assign err_ovr = err_ovr_q;
`else
  logic unused_ev;
  assign unused_ev = ^{ev_chk, ev_len, ev_tmo, ev_ovr};
`endif

endmodule

// File: tb/tb_bridge_rsp_decoder.sv
// tb/tb_bridge_rsp_decoder.sv - directed self-checking bench for bridge_rsp_decoder.
// Counter checks are active when BRIDGE_DEC_STATS_EN is defined.
module tb_bridge_rsp_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_frame_err = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_last, pong_seen, busy;
`ifdef BRIDGE_DEC_STATS_EN
  logic [7:0] err_chk, err_len, err_tmo, err_ovr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap_data[$];
  logic       cap_last[$];
  int         pong_cnt, unstable_cnt;

  always #5 clk = ~clk;

  bridge_rsp_decoder #(.MAX_LEN(16), .TIMEOUT_CYCLES(480)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .pong_seen    (pong_seen),
    .busy         (busy)
`ifdef BRIDGE_DEC_STATS_EN
    ,
    .err_chk      (err_chk),
    .err_len      (err_len),
    .err_tmo      (err_tmo),
    .err_ovr      (err_ovr)
`endif
  );

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) begin
      @(negedge clk);
      rx_data  = q[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Records handshaken beats until the last one; also counts pong pulses and stall instability.
  task automatic capture(input bit toggle, input int budget);
    bit held = 0;
    bit done = 0;
    logic [7:0] hd = '0;
    logic hl = 1'b0;
    cap_data.delete();
    cap_last.delete();
    pong_cnt = 0;
    unstable_cnt = 0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (held && (!out_valid || out_data !== hd || out_last !== hl)) unstable_cnt++;
      if (pong_seen) pong_cnt++;
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
        if (out_last) done = 1;
        held = 0;
      end else if (out_valid) begin
        held = 1; hd = out_data; hl = out_last;
      end else begin
        held = 0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (pong_seen !== 1'b0) begin n_bad++; $display("FAIL reset_pong: got %b want 0", pong_seen); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef BRIDGE_DEC_STATS_EN
    n_cmp++; if ({err_chk, err_len, err_tmo, err_ovr} !== 32'h0) begin n_bad++; $display("FAIL reset_counters: got %h want 0", {err_chk, err_len, err_tmo, err_ovr}); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pong;
    logic [7:0] exp[$];
    exp = '{8'h81, 8'h00};
    send_bytes('{8'hA5, 8'h81, 8'h00, 8'h81});
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h81) begin n_bad++; $display("FAIL pong_latency: got v=%b d=%h want v=1 d=81", out_valid, out_data); end
    capture(1'b0, 20);
    n_cmp++; if (cap_data.size() !== exp.size()) begin n_bad++; $display("FAIL pong_beats: got %0d want %0d", cap_data.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == exp.size() - 1)) begin n_bad++; $display("FAIL pong_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], (i == exp.size() - 1)); end
    end
    n_cmp++; if (pong_cnt !== 1) begin n_bad++; $display("FAIL pong_pulse: got %0d want 1", pong_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pong_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_stall;
    logic [7:0] exp[$];
    exp = '{8'h10, 8'h03, 8'h01, 8'h02, 8'h03};
    send_bytes('{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19});
    capture(1'b1, 40);
    n_cmp++; if (cap_data.size() !== exp.size()) begin n_bad++; $display("FAIL stall_beats: got %0d want %0d", cap_data.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == exp.size() - 1)) begin n_bad++; $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], (i == exp.size() - 1)); end
    end
    n_cmp++; if (unstable_cnt !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", unstable_cnt); end
    n_cmp++; if (pong_cnt !== 0) begin n_bad++; $display("FAIL stall_no_pong: got %0d want 0", pong_cnt); end
  endtask

  task automatic test_bad_chk;
    logic [7:0] exp[$];
    bit seen = 0;
    exp = '{8'h20, 8'h01, 8'h07};
    send_bytes('{8'hA5, 8'h10, 8'h02, 8'h05, 8'h05, 8'h00});
    for (int i = 0; i < 6; i++) begin
      #1; if (out_valid) seen = 1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL badchk_no_valid: got %b want 0", seen); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL badchk_busy: got %b want 0", busy); end
`ifdef BRIDGE_DEC_STATS_EN
    n_cmp++; if (err_chk !== 8'd1) begin n_bad++; $display("FAIL badchk_count: got %0d want 1", err_chk); end
`endif
    send_bytes('{8'hA5, 8'h20, 8'h01, 8'h07, 8'h28});
    capture(1'b0, 20);
    n_cmp++; if (cap_data.size() !== exp.size()) begin n_bad++; $display("FAIL badchk_next_beats: got %0d want %0d", cap_data.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == exp.size() - 1)) begin n_bad++; $display("FAIL badchk_next_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], (i == exp.size() - 1)); end
    end
  endtask

  task automatic test_len_garbage;
    logic [7:0] exp[$];
    exp = '{8'h01, 8'h00};
    send_bytes('{8'hA5, 8'h10, 8'h11});
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len_busy: got %b want 0", busy); end
`ifdef BRIDGE_DEC_STATS_EN
    n_cmp++; if (err_len !== 8'd1) begin n_bad++; $display("FAIL len_count: got %0d want 1", err_len); end
`endif
    send_bytes('{8'h00, 8'hFF, 8'h12});
    #1;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL garbage_idle: got busy=%b valid=%b want 0/0", busy, out_valid); end
    send_bytes('{8'hA5, 8'h01, 8'h00, 8'h01});
    capture(1'b0, 20);
    n_cmp++; if (cap_data.size() !== exp.size()) begin n_bad++; $display("FAIL garbage_beats: got %0d want %0d", cap_data.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == exp.size() - 1)) begin n_bad++; $display("FAIL garbage_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], (i == exp.size() - 1)); end
    end
  endtask

  task automatic test_timeout;
    logic [7:0] exp[$];
    exp = '{8'h10, 8'h00};
    // Next byte lands on the expiry clock: it must be accepted.
    send_bytes('{8'hA5, 8'h10});
    repeat (478) @(negedge clk);
    send_bytes('{8'h00, 8'h10});
    capture(1'b0, 20);
    n_cmp++; if (cap_data.size() !== exp.size()) begin n_bad++; $display("FAIL tmo_edge_beats: got %0d want %0d", cap_data.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == exp.size() - 1)) begin n_bad++; $display("FAIL tmo_edge_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], (i == exp.size() - 1)); end
    end
    send_bytes('{8'hA5, 8'h10});
    repeat (479) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tmo_before: got busy=%b want 1", busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_after: got busy=%b want 0", busy); end
`ifdef BRIDGE_DEC_STATS_EN
    n_cmp++; if (err_tmo !== 8'd1) begin n_bad++; $display("FAIL tmo_count: got %0d want 1", err_tmo); end
`endif
  endtask

  task automatic test_frame_err;
    logic [7:0] exp[$];
    exp = '{8'h20, 8'h00};
    send_bytes('{8'hA5, 8'h10, 8'h03, 8'h01});
    rx_frame_err = 1'b1;
    @(negedge clk);
    rx_frame_err = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy: got %b want 0", busy); end
    @(negedge clk);
    rx_frame_err = 1'b1;
    @(negedge clk);
    rx_frame_err = 1'b0;
`ifdef BRIDGE_DEC_STATS_EN
    #1;
    n_cmp++; if (err_tmo !== 8'd2) begin n_bad++; $display("FAIL ferr_count: got %0d want 2", err_tmo); end
`endif
    send_bytes('{8'hA5, 8'h20, 8'h00, 8'h20});
    capture(1'b0, 20);
    n_cmp++; if (cap_data.size() !== exp.size()) begin n_bad++; $display("FAIL ferr_next_beats: got %0d want %0d", cap_data.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == exp.size() - 1)) begin n_bad++; $display("FAIL ferr_next_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], (i == exp.size() - 1)); end
    end
  endtask

  task automatic test_overrun_reset;
    logic [7:0] exp[$];
    bit seen = 0;
    exp = '{8'h10, 8'h01, 8'h44};
    out_ready = 1'b0;
    send_bytes('{8'hA5, 8'h10, 8'h01, 8'h44, 8'h55});
    send_bytes('{8'hA5, 8'h10, 8'h01});
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin n_bad++; $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=10", out_valid, out_data); end
`ifdef BRIDGE_DEC_STATS_EN
    n_cmp++; if (err_ovr !== 8'd3) begin n_bad++; $display("FAIL ovr_count: got %0d want 3", err_ovr); end
`endif
    capture(1'b0, 20);
    n_cmp++; if (cap_data.size() !== exp.size()) begin n_bad++; $display("FAIL ovr_beats: got %0d want %0d", cap_data.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp[i] || cap_last[i] !== (i == exp.size() - 1)) begin n_bad++; $display("FAIL ovr_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp[i], (i == exp.size() - 1)); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovr_busy_after: got %b want 0", busy); end

    send_bytes('{8'hA5, 8'h81, 8'h00, 8'h81});
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (out_data !== 8'h00 || out_last !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got d=%h l=%b want d=00 l=1", out_data, out_last); end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if ({out_valid, out_last, out_data, pong_seen, busy} !== 12'h000) begin n_bad++; $display("FAIL rst_mid_emit: got v=%b l=%b d=%h p=%b b=%b want all 0", out_valid, out_last, out_data, pong_seen, busy); end
`ifdef BRIDGE_DEC_STATS_EN
    n_cmp++; if ({err_chk, err_len, err_tmo, err_ovr} !== 32'h0) begin n_bad++; $display("FAIL rst_counters: got %h want 0", {err_chk, err_len, err_tmo, err_ovr}); end
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1; if (out_valid) seen = 1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_quiet: got %b want 0", seen); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pong();
    test_stall();
    test_bad_chk();
    test_len_garbage();
    test_timeout();
    test_frame_err();
    test_overrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bridge_rsp_decoder.md
# bridge_rsp_decoder

Receive-side decoder for the KMBox bridge protocol, sitting between `uart_rx` and the response FIFO inside the FPGA bridge. It hunts for sync bytes, parses CMD/LEN/payload/checksum frames from the 3 Mbaud byte stream, buffers each frame, and releases only checksum-valid frames to a valid/ready byte stream. It also pulses a keepalive indication on valid PONG frames and aborts frames on inter-byte timeout or UART framing error.

## Interface
- `MAX_LEN`, 16: largest accepted payload length in bytes (1..255).
- `TIMEOUT_CYCLES`, 480: maximum idle clocks between bytes inside a frame (480 clocks = 3 byte times at 48 MHz / 3 Mbaud).
- `clk` in 1: system clock, 48 MHz.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx_data` in 8: received byte from `uart_rx`.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `rx_frame_err` in 1: one-cycle strobe for a UART stop-bit error.
- `out_data` out 8: output stream byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the current byte.
- `out_last` out 1: marks the final byte of a frame.
- `pong_seen` out 1: one-cycle pulse when a valid frame with CMD=PONG is emitted.
- `busy` out 1: high in every state except HUNT.
- `err_chk`, `err_len`, `err_tmo`, `err_ovr` out 8 each: error counters. These ports are present only under `BRIDGE_DEC_STATS_EN`.

## Operation
- Frame format: SYNC (0xA5), CMD, LEN, LEN payload bytes, CHK. CHK = (CMD + LEN + sum of payload) mod 256.
- States and transitions:
  - HUNT: discard bytes until 0xA5, then go to CMD.
  - CMD: store the byte, go to LEN.
  - LEN: if LEN > MAX_LEN, count a length error and return to HUNT. Otherwise go to PAYLOAD, or to CHK when LEN = 0.
  - PAYLOAD: write each byte to the buffer at index 0..LEN-1. After the last byte, go to CHK.
  - CHK: on a match, go to EMIT. On a mismatch, count a checksum error and return to HUNT.
  - EMIT: send CMD, then LEN, then the payload, asserting `out_last` on the final beat. The stream is always at least 2 beats. After the last handshake, return to HUNT.
- 0xA5 appearing at the CMD, LEN, payload or CHK position is treated as data. There is no resync mid-frame.
- Running sum and all indices are 8-bit with wrap.
- `rx_valid` during EMIT: the byte is dropped and an overrun is counted. The decoder does not preload the next frame.
- `rx_frame_err` in CMD/LEN/PAYLOAD/CHK: abort to HUNT and count a timeout error. In HUNT it is ignored. In EMIT it is ignored; the emission completes.
- Timeout: a counter reloads on every `rx_valid` and runs only in CMD/LEN/PAYLOAD/CHK. On reaching TIMEOUT_CYCLES it aborts to HUNT and counts a timeout error.
- `rx_valid` and timeout expiry in the same cycle: the byte wins and the timer reloads.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `pong_seen`=0, `busy`=0, all counters 0, state HUNT.
- Latency: the cycle after the CHK byte's `rx_valid` has `out_valid`=1 with `out_data`=CMD.
- Handshake: a beat transfers when `out_valid && out_ready`. `out_data` and `out_last` stay stable while `out_valid && !out_ready`. With `out_ready` held high, the decoder emits one beat per clock.
- `pong_seen` pulses in the same cycle as the last-beat handshake of a PONG frame.
- Reset mid-frame or mid-emit: the next cycle is HUNT with all outputs at reset values. The buffer is not cleared.

## Configuration
- `BRIDGE_DEC_STATS_EN` defined: the four 8-bit error counters exist, each saturating at 0xFF.
- Not defined: the counter ports and logic are absent. All error conditions still abort or drop identically.

## Structure
- Shared package `bridge_pkg`: SYNC byte (0xA5), CMD codes (PING 0x01, PONG 0x81, MOUSE 0x10, KBD 0x20), and the state encoding.
- One sub-module, `bridge_frame_buf`: MAX_LEN×8 single-port register/RAM with synchronous write and registered read. EMIT prefetches one entry so the beat rate stays one per clock.

## Test plan
- A5 81 00 81 with `out_ready`=1 -> beats 81, 00 (`last`); `pong_seen` pulses once.
- A5 10 03 01 02 03 19 with `out_ready` toggling 1/0 -> beats 10, 03, 01, 02, 03 (`last`), each held stable while stalled.
- A5 10 02 05 05 00 (bad CHK) -> no `out_valid`; `err_chk`=1. A following valid frame is emitted correctly.
- A5 10 11 (LEN=17 > 16) -> `err_len`=1, back in HUNT. Garbage 00 FF 12 before a valid frame -> discarded.
- A5 10, then 481 idle clocks -> `err_tmo`=1, `busy`=0. Also `rx_frame_err` mid-payload -> `err_tmo` increments.
- Valid frame with `out_ready`=0 while 3 more bytes arrive -> `err_ovr`=3. `rst_n` low mid-emit -> all outputs 0 the next cycle.
